// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Sequencing controller for a 5-stage (IF/ID/EX/MEM/WB) pipeline.
// It tracks the destinations of the instructions in EX, MEM and WB in a
// 3-slot scoreboard. From that it decides whether the instruction in ID may
// issue, and it drives the pipeline-register controls. It also sequences the
// drain that follows a HALT.
//
// Parameters
//   FWD      : 1 = forwarding network present, stall only on load-use
//              0 = no forwarding, stall on any RAW hit in EX or MEM
//   REG_BITS : register specifier width
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   id_valid     in   ID holds a valid instruction
//   id_rs/id_rt  in   source register specifiers
//   id_rs_used   in   instruction reads id_rs
//   id_rt_used   in   instruction reads id_rt
//   id_rd        in   destination register (after the RegDst mux)
//   id_regwrite  in   decoded RegWrite
//   id_memtoreg  in   decoded MemToReg (the instruction is a load)
//   id_halt      in   decoded HaltPC
//   ex_redirect  in   branch taken or jump resolved in EX
//   mem_stall    in   data memory busy
//   stall_f      out  hold the PC and IF/ID
//   bubble_id    out  load a NOP into ID/EX
//   flush_f      out  squash IF/ID
//   freeze_all   out  hold every pipeline register
//   halted       out  pipeline drained after a HALT
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FWD      = 1,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memtoreg,
  input  logic                id_halt,
  input  logic                ex_redirect,
  input  logic                mem_stall,
  output logic                stall_f,
  output logic                bubble_id,
  output logic                flush_f,
  output logic                freeze_all,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int SLOTS = 3;  // index 0 = EX, 1 = MEM, 2 = WB

  // Scoreboard storage
  logic [SLOTS-1:0]    r_sb_v;
  logic [SLOTS-1:0]    r_sb_wr;
  logic [SLOTS-1:0]    r_sb_ld;
  logic [REG_BITS-1:0] r_sb_rd [0:SLOTS-1];

  // Halt sequencing
  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_next;

  // Hazard detection and control
  logic [SLOTS-1:0] w_hit;
  logic             w_raw;
  logic             w_issue;
  logic             w_stall;
  logic             w_bubble;
  logic             w_flush;
  logic             w_freeze;

  // ---------------------------------------------------------------------------
  // Per-slot match between the ID sources and the in-flight destination.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_hit
      assign w_hit[gi] = r_sb_v[gi] & r_sb_wr[gi] &
                         ((id_rs_used & (id_rs == r_sb_rd[gi])) |
                          (id_rt_used & (id_rt == r_sb_rd[gi])));
    end
  endgenerate

  // WB never causes a stall. The register file writes before it reads, so a
  // value in WB is already visible to ID.
  generate
    if (FWD != 0) begin : g_raw_fwd
      assign w_raw = id_valid & w_hit[0] & r_sb_ld[0];
    end else begin : g_raw_nofwd
      assign w_raw = id_valid & (w_hit[0] | w_hit[1]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control outputs, in priority order.
  // A memory stall freezes everything, so no other action may take effect in
  // that cycle. A redirect beats the RAW stall because the dependent
  // instruction is being squashed anyway.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_freeze = 1'b0;
    if (mem_stall) begin
      w_freeze = 1'b1;
    end else if (ex_redirect) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (r_state != ST_RUN) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_raw) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  assign w_issue = id_valid & ~w_stall & ~w_flush & ~mem_stall &
                   (r_state == ST_RUN);

  // The outputs are forced low while reset is held, even though mem_stall or
  // ex_redirect may be asserted by logic that is not in reset.
  assign stall_f    = rst & w_stall;
  assign bubble_id  = rst & w_bubble;
  assign flush_f    = rst & w_flush;
  assign freeze_all = rst & w_freeze;
  assign halted     = rst & (r_state == ST_HALTED);

  // ---------------------------------------------------------------------------
  // Scoreboard shift. Every slot holds while memory is busy. EX takes the
  // issued instruction, or an empty slot when nothing issued (a bubble or a
  // squash). A HALT enters as a non-writing NOP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_v  <= '0;
      r_sb_wr <= '0;
      r_sb_ld <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_sb_rd[i] <= '0;
      end
    end else if (!mem_stall) begin
      for (int i = SLOTS - 1; i > 0; i--) begin
        r_sb_v[i]  <= r_sb_v[i-1];
        r_sb_wr[i] <= r_sb_wr[i-1];
        r_sb_ld[i] <= r_sb_ld[i-1];
        r_sb_rd[i] <= r_sb_rd[i-1];
      end
      r_sb_v[0]  <= w_issue;
      r_sb_wr[0] <= id_regwrite & ~id_halt;
      r_sb_ld[0] <= id_memtoreg & ~id_halt;
      r_sb_rd[0] <= id_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt FSM. The drain counter covers the HALT moving from EX to MEM to WB
  // and then retiring. Only cycles in which memory is not busy count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        // A HALT squashed by an older redirect has w_issue=0 and never drains.
        if (w_issue && id_halt) begin
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = 2'd3;
        end
      end
      ST_DRAIN: begin
        if (!mem_stall) begin
          if (r_drain_cnt == 2'd0) begin
            w_state_next = ST_HALTED;
          end else begin
            w_drain_cnt_next = r_drain_cnt - 2'd1;
          end
        end
      end
      ST_HALTED: begin
        // Only reset leaves this state.
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next     = ST_RUN;
        w_drain_cnt_next = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [2:0] id_rd;
  logic       id_regwrite;
  logic       id_memtoreg;
  logic       id_halt;
  logic       ex_redirect;
  logic       mem_stall;

  logic f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted;
  logic f0_stall, f0_bubble, f0_flush, f0_freeze, f0_halted;

  int total;
  int bad;

  hazard_ctrl #(.FWD(1), .REG_BITS(3)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stall_f(f1_stall), .bubble_id(f1_bubble), .flush_f(f1_flush),
    .freeze_all(f1_freeze), .halted(f1_halted)
  );

  hazard_ctrl #(.FWD(0), .REG_BITS(3)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stall_f(f0_stall), .bubble_id(f0_bubble), .flush_f(f0_flush),
    .freeze_all(f0_freeze), .halted(f0_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_rd = 0; id_regwrite = 0; id_memtoreg = 0; id_halt = 0;
    ex_redirect = 0; mem_stall = 0;
  endtask

  // Present one instruction in ID.
  task automatic put_id(input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                        input logic rtu, input logic [2:0] rd, input logic rw,
                        input logic ld, input logic hlt);
    id_valid = 1; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_regwrite = rw; id_memtoreg = ld; id_halt = hlt;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    mem_stall = 1; ex_redirect = 1;
    put_id(3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 1);
    @(negedge clk);
    total++; if (f1_freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze1: got %b want 0", f1_freeze); end
    total++; if (f1_flush  !== 1'b0) begin bad++; $display("FAIL rst_flush1: got %b want 0", f1_flush); end
    total++; if (f1_stall  !== 1'b0) begin bad++; $display("FAIL rst_stall1: got %b want 0", f1_stall); end
    total++; if (f1_bubble !== 1'b0) begin bad++; $display("FAIL rst_bubble1: got %b want 0", f1_bubble); end
    total++; if (f1_halted !== 1'b0) begin bad++; $display("FAIL rst_halted1: got %b want 0", f1_halted); end
    total++; if (f0_freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze0: got %b want 0", f0_freeze); end
    total++; if (f0_flush  !== 1'b0) begin bad++; $display("FAIL rst_flush0: got %b want 0", f0_flush); end
    $display("reset: outputs while rst=0 stall=%b bubble=%b flush=%b freeze=%b halted=%b",
             f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted);
    tick();
    idle();
    rst = 1;
    @(negedge clk);
    total++; if ({f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted} !== 5'b0) begin
      bad++; $display("FAIL rst_idle: got %b want 00000", {f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted});
    end
    tick();
  endtask

  task automatic test_load_use();
    // LD r3, then a reader of r3: exactly one stall cycle with forwarding.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL lu_ld_issue: got %b want 0", f1_stall); end
    tick();
    put_id(3'd3, 1, 3'd0, 0, 3'd5, 1, 0, 0);
    @(negedge clk);
    total++; if (f1_stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", f1_stall); end
    total++; if (f1_bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble: got %b want 1", f1_bubble); end
    $display("load-use cycle1: stall=%b bubble=%b", f1_stall, f1_bubble);
    tick();
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", f1_stall); end
    $display("load-use cycle2: stall=%b", f1_stall);
    tick();
    // Same pattern with an unrelated source register.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
    tick();
    put_id(3'd4, 1, 3'd0, 0, 3'd5, 1, 0, 0);
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL lu_nodep: got %b want 0", f1_stall); end
    $display("load-use rs=r4: stall=%b", f1_stall);
    // A load read through rt must stall as well.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0);
    tick();
    put_id(3'd1, 1, 3'd6, 1, 3'd2, 1, 0, 0);
    @(negedge clk);
    total++; if (f1_stall !== 1'b1) begin bad++; $display("FAIL lu_rt: got %b want 1", f1_stall); end
    $display("load-use via rt: stall=%b", f1_stall);
    tick();
  endtask

  task automatic test_raw_nofwd();
    // Gap 0: two stall cycles.
    do_reset();
    put_id(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    tick();
    put_id(3'd2, 1, 3'd0, 0, 3'd4, 1, 0, 0);
    @(negedge clk);
    total++; if (f0_stall !== 1'b1) begin bad++; $display("FAIL raw0_c1: got %b want 1", f0_stall); end
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL raw0_fwd: got %b want 0", f1_stall); end
    tick();
    @(negedge clk);
    total++; if (f0_stall !== 1'b1) begin bad++; $display("FAIL raw0_c2: got %b want 1", f0_stall); end
    tick();
    @(negedge clk);
    total++; if (f0_stall !== 1'b0) begin bad++; $display("FAIL raw0_c3: got %b want 0", f0_stall); end
    $display("raw gap0: third cycle stall=%b", f0_stall);
    tick();
    // Gap 1: one stall cycle.
    do_reset();
    put_id(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    tick();
    put_id(3'd1, 1, 3'd0, 0, 3'd4, 1, 0, 0);
    @(negedge clk);
    total++; if (f0_stall !== 1'b0) begin bad++; $display("FAIL raw1_mid: got %b want 0", f0_stall); end
    tick();
    put_id(3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0);
    @(negedge clk);
    total++; if (f0_stall !== 1'b1) begin bad++; $display("FAIL raw1_c1: got %b want 1", f0_stall); end
    tick();
    @(negedge clk);
    total++; if (f0_stall !== 1'b0) begin bad++; $display("FAIL raw1_c2: got %b want 0", f0_stall); end
    $display("raw gap1: second cycle stall=%b", f0_stall);
    tick();
    // Gap 2: no stall, the producer is in WB.
    do_reset();
    put_id(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    tick();
    put_id(3'd1, 1, 3'd0, 0, 3'd4, 1, 0, 0);
    tick();
    put_id(3'd3, 1, 3'd0, 0, 3'd6, 1, 0, 0);
    tick();
    put_id(3'd2, 1, 3'd0, 0, 3'd5, 1, 0, 0);
    @(negedge clk);
    total++; if (f0_stall !== 1'b0) begin bad++; $display("FAIL raw2: got %b want 0", f0_stall); end
    $display("raw gap2: stall=%b", f0_stall);
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
    tick();
    put_id(3'd3, 1, 3'd0, 0, 3'd5, 1, 1, 0);
    ex_redirect = 1;
    @(negedge clk);
    total++; if (f1_flush !== 1'b1) begin bad++; $display("FAIL redir_flush: got %b want 1", f1_flush); end
    total++; if (f1_bubble !== 1'b1) begin bad++; $display("FAIL redir_bubble: got %b want 1", f1_bubble); end
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL redir_stall: got %b want 0", f1_stall); end
    $display("redirect: flush=%b bubble=%b stall=%b", f1_flush, f1_bubble, f1_stall);
    tick();
    ex_redirect = 0;
    // The squashed load of r5 must not occupy EX: a reader of r5 issues.
    put_id(3'd5, 1, 3'd0, 0, 3'd1, 1, 0, 0);
    @(negedge clk);
    total++; if (u1.r_sb_v[0] !== 1'b0) begin bad++; $display("FAIL redir_exslot: got %b want 0", u1.r_sb_v[0]); end
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL redir_nodep: got %b want 0", f1_stall); end
    tick();
    // A HALT squashed by a redirect never drains.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    ex_redirect = 1;
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    total++; if (f1_halted !== 1'b0) begin bad++; $display("FAIL redir_halt: got %b want 0", f1_halted); end
    put_id(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    #1;
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL redir_halt_run: got %b want 0", f1_stall); end
    $display("squashed halt: halted=%b stall=%b", f1_halted, f1_stall);
    tick();
  endtask

  task automatic test_halt();
    logic [5:0] ms_pat;
    // Plain drain: halted after the fourth edge following the issuing edge.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL halt_issue: got %b want 0", f1_stall); end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (f1_halted !== 1'b0) begin bad++; $display("FAIL halt_early%0d: got %b want 0", i, f1_halted); end
      total++; if (f1_stall !== 1'b1) begin bad++; $display("FAIL halt_drain_stall%0d: got %b want 1", i, f1_stall); end
      tick();
    end
    @(negedge clk);
    total++; if (f1_halted !== 1'b1) begin bad++; $display("FAIL halt_done: got %b want 1", f1_halted); end
    total++; if (f1_stall !== 1'b1 || f1_bubble !== 1'b1) begin
      bad++; $display("FAIL halt_hold: got stall=%b bubble=%b want 1 1", f1_stall, f1_bubble);
    end
    $display("halt: halted=%b after 4 edges", f1_halted);
    tick();
    // Drain with two memory-stall cycles: two extra edges.
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    tick();
    idle();
    ms_pat = 6'b000110;  // bit i = mem_stall during drain cycle i
    for (int i = 0; i < 6; i++) begin
      mem_stall = ms_pat[i];
      @(negedge clk);
      total++; if (f1_halted !== 1'b0) begin bad++; $display("FAIL halt_ms_early%0d: got %b want 0", i, f1_halted); end
      if (ms_pat[i]) begin
        total++; if (f1_freeze !== 1'b1) begin bad++; $display("FAIL halt_ms_freeze%0d: got %b want 1", i, f1_freeze); end
      end else begin
        total++; if (f1_stall !== 1'b1) begin bad++; $display("FAIL halt_ms_stall%0d: got %b want 1", i, f1_stall); end
      end
      tick();
    end
    mem_stall = 0;
    @(negedge clk);
    total++; if (f1_halted !== 1'b1) begin bad++; $display("FAIL halt_ms_done: got %b want 1", f1_halted); end
    $display("halt with mem_stall: halted=%b after 6 edges", f1_halted);
    tick();
  endtask

  task automatic test_mem_stall();
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0);
    tick();
    put_id(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (f1_freeze !== 1'b1) begin bad++; $display("FAIL ms_freeze%0d: got %b want 1", i, f1_freeze); end
      total++; if (f1_stall !== 1'b0 || f1_bubble !== 1'b0) begin
        bad++; $display("FAIL ms_ctrl%0d: got stall=%b bubble=%b want 0 0", i, f1_stall, f1_bubble);
      end
      tick();
    end
    mem_stall = 0;
    @(negedge clk);
    total++; if (f1_stall !== 1'b1) begin bad++; $display("FAIL ms_lu: got %b want 1", f1_stall); end
    total++; if (f1_freeze !== 1'b0) begin bad++; $display("FAIL ms_unfreeze: got %b want 0", f1_freeze); end
    $display("after mem_stall: stall=%b freeze=%b", f1_stall, f1_freeze);
    tick();
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL ms_release: got %b want 0", f1_stall); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    put_id(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    tick();
    idle();
    tick();
    #2;
    rst = 0;
    mem_stall = 1;
    #1;
    total++; if ({f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted} !== 5'b0) begin
      bad++; $display("FAIL arst_out: got %b want 00000", {f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted});
    end
    total++; if (u1.r_sb_v !== 3'b000) begin bad++; $display("FAIL arst_sb: got %b want 000", u1.r_sb_v); end
    $display("async reset mid-drain: outputs=%b", {f1_stall, f1_bubble, f1_flush, f1_freeze, f1_halted});
    mem_stall = 0;
    rst = 1;
    put_id(3'd7, 1, 3'd3, 1, 3'd2, 1, 0, 0);
    @(negedge clk);
    total++; if (f1_stall !== 1'b0) begin bad++; $display("FAIL arst_issue1: got %b want 0", f1_stall); end
    total++; if (f0_stall !== 1'b0) begin bad++; $display("FAIL arst_issue0: got %b want 0", f0_stall); end
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    total++; if (f1_halted !== 1'b0) begin bad++; $display("FAIL arst_run: got %b want 0", f1_halted); end
    $display("after async reset: halted=%b", f1_halted);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst = 0;
    #1;
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_redirect();
    test_halt();
    test_mem_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) WISC core.
- Consumes the decoded control of the instruction in ID (RegWrite, MemToReg, HaltPC), tracks in-flight destinations in a 3-slot scoreboard, and issues stall, bubble, flush and freeze to the pipeline registers.
- Also sequences the halt drain.

Parameters:
FWD, 1, 1 = forwarding present, stall only on load-use; 0 = stall on any RAW hit in EX or MEM.
REG_BITS, 3, register specifier width.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
id_valid  input  1  ID stage holds a valid instruction
id_rs  input  REG_BITS  first source register
id_rt  input  REG_BITS  second source register
id_rs_used  input  1  instruction reads id_rs
id_rt_used  input  1  instruction reads id_rt
id_rd  input  REG_BITS  destination register (post RegDst mux)
id_regwrite  input  1  decoded RegWrite
id_memtoreg  input  1  decoded MemToReg (load)
id_halt  input  1  decoded HaltPC
ex_redirect  input  1  branch taken or jump resolved in EX
mem_stall  input  1  data memory busy
stall_f  output  1  hold PC and IF/ID
bubble_id  output  1  load NOP into ID/EX
flush_f  output  1  squash IF/ID
freeze_all  output  1  hold every pipeline register
halted  output  1  pipeline drained after HALT

Behaviour:
- Reset (rst=0, async): scoreboard slots invalid, FSM=RUN, drain counter=0. All outputs 0 while rst=0.
- Scoreboard: slots EX, MEM, WB, each holding {v, rd, wr, ld}.
  - Advance only when mem_stall=0: WB<=MEM, MEM<=EX, EX<=issued ID instruction, or invalid if nothing issued.
  - mem_stall=1: all slots hold.
- issue = id_valid & ~stall_f & ~flush_f & ~mem_stall & FSM==RUN.
- Match rule: hit(s) = s.v & s.wr & ((id_rs_used & id_rs==s.rd) | (id_rt_used & id_rt==s.rd)).
- RAW stall:
  - FWD=1: raw = hit(EX) & EX.ld.
  - FWD=0: raw = hit(EX) | hit(MEM). WB is excluded because the register file bypasses write-before-read.
  - raw requires id_valid.
- Priority, combinational, highest first:
  1. mem_stall → freeze_all=1, all other control outputs 0.
  2. ex_redirect → flush_f=1, bubble_id=1, stall_f=0. Redirect overrides raw.
  3. FSM!=RUN → stall_f=1, bubble_id=1.
  4. raw → stall_f=1, bubble_id=1.
  5. Otherwise all 0.
- Redirect vs. scoreboard: the branch itself stays in the EX slot, since JAL/JALR write R7. The squashed ID instruction never enters the scoreboard.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN→DRAIN: when issue & id_halt. Drain counter loads 3. The HALT occupies EX like a NOP with wr=0.
  - DRAIN: counter decrements on each cycle with mem_stall=0. At counter==0 with mem_stall=0, go to HALTED.
  - HALTED: halted=1, stall_f=1, bubble_id=1. Exit only by reset.
  - A HALT in ID with an older redirect in EX is squashed and never enters DRAIN.
- Latency:
  - Load-use stall lasts exactly 1 cycle with FWD=1.
  - RAW on EX with FWD=0 lasts 2 cycles; RAW on MEM only lasts 1 cycle.
- Reset mid-drain or mid-stall: returns to RUN with an empty scoreboard immediately, without waiting for a clock edge.

Test Plan:
- FWD=1: LD r3 issued, next cycle ID reads rs=r3 → stall_f=bubble_id=1 for 1 cycle; issue on the following cycle. Repeat with rs=r4 → no stall.
- FWD=0: ADD r2 followed by SUB reading r2 → stall_f=1 for 2 cycles. With one unrelated instruction between → 1 cycle. With two between → 0.
- ex_redirect=1 while ID holds a load-use dependent → flush_f=1, bubble_id=1, stall_f=0 that cycle. Scoreboard EX slot next cycle is invalid.
- HALT issued at cycle t with mem_stall=0 → halted=1 at cycle t+4. Insert mem_stall=1 for 2 cycles during DRAIN → halted=1 at t+6. stall_f stays 1 throughout.
- mem_stall=1 for 3 cycles while LD r1 is in EX and ID reads r1 → freeze_all=1 and stall_f=0 during the stall. The load-use stall appears on the first cycle after mem_stall drops, and the scoreboard is unchanged.
- Assert rst=0 asynchronously mid-cycle during DRAIN → all outputs 0 at once. After release, FSM=RUN, and an ID instruction reading any register issues without stall.
